// File: rtl/packet_gen_sequencer.sv
// Sequences test-packet launches once the transceiver PLL has locked and settled:
// configurable bursts with programmable gaps, generator back-pressure and lock-loss abort.
module packet_gen_sequencer #(
    parameter int unsigned LOCK_SETTLE_CYCLES = 1024,
    parameter int unsigned GAP_WIDTH          = 16,
    parameter int unsigned COUNT_WIDTH        = 32
) (
    input  logic                   clk_ref156,
    input  logic                   rst_n,
    input  logic                   pll_lock,
    input  logic                   start,
    input  logic                   stop,
    input  logic [15:0]            burst_len,
    input  logic [GAP_WIDTH-1:0]   gap_cycles,
    input  logic                   gen_busy,
    output logic                   packet_gen_en,
    output logic                   ready,
    output logic                   running,
    output logic                   done,
    output logic                   lock_lost,
    output logic [COUNT_WIDTH-1:0] packets_sent
);

    localparam int unsigned SW = (LOCK_SETTLE_CYCLES > 1) ? $clog2(LOCK_SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(LOCK_SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_SETTLE    = 3'd1,
        ST_ARMED     = 3'd2,
        ST_SEND      = 3'd3,
        ST_GAP       = 3'd4,
        ST_DONE      = 3'd5
    } state_e;

    state_e                 state_q, state_d;
    logic [SW-1:0]          settle_q, settle_d;
    logic [GAP_WIDTH-1:0]   gap_cnt_q, gap_cnt_d;
    logic [GAP_WIDTH-1:0]   gap_len_q, gap_len_d;
    logic [15:0]            blen_q, blen_d;
    logic [15:0]            idx_q, idx_d;
    logic [COUNT_WIDTH-1:0] pkts_q, pkts_d;
    logic                   launch_q, launch_d;
    logic                   ready_q, ready_d;
    logic                   running_q, running_d;
    logic                   done_q, done_d;
    logic                   lock_lost_q, lock_lost_d;
    logic                   lock_meta_q, lock_sync_q;

    logic lock_s;
    logic start_burst_s;
    logic launch_s;
    logic last_pkt_s;

    assign lock_s        = lock_sync_q;
    assign start_burst_s = (state_q == ST_ARMED) && lock_s && start;
    assign launch_s      = (state_q == ST_SEND) && lock_s && !gen_busy;
    assign last_pkt_s    = (blen_q != 16'd0) && ((idx_q + 16'd1) == blen_q);

    // Two-flop synchroniser for the asynchronous PLL lock indication.
    always_ff @(posedge clk_ref156 or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
        end else begin
            lock_meta_q <= pll_lock;
            lock_sync_q <= lock_meta_q;
        end
    end

    // State register together with the settle and gap counters it steers.
    always_ff @(posedge clk_ref156 or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_WAIT_LOCK;
            settle_q  <= {SW{1'b0}};
            gap_cnt_q <= {GAP_WIDTH{1'b0}};
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    // Next-state logic; lock loss overrides every request outside WAIT_LOCK.
    always_comb begin
        state_d   = state_q;
        settle_d  = settle_q;
        gap_cnt_d = gap_cnt_q;
        case (state_q)
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d  = ST_SETTLE;
                    settle_d = {SW{1'b0}};
                end else begin
                    state_d = ST_WAIT_LOCK;
                end
            end
            ST_SETTLE: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                end else if (settle_q == SETTLE_LAST) begin
                    state_d = ST_ARMED;
                end else begin
                    settle_d = settle_q + {{(SW-1){1'b0}}, 1'b1};
                end
            end
            ST_ARMED: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                end else if (start) begin
                    state_d = ST_SEND;
                end else begin
                    state_d = ST_ARMED;
                end
            end
            ST_SEND: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                end else if (stop) begin
                    state_d = ST_ARMED;
                end else if (gen_busy) begin
                    state_d = ST_SEND;
                end else if (last_pkt_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d   = ST_GAP;
                    gap_cnt_d = gap_len_q;
                end
            end
            ST_GAP: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                end else if (stop) begin
                    state_d = ST_ARMED;
                end else if (gap_cnt_q == {GAP_WIDTH{1'b0}}) begin
                    state_d = ST_SEND;
                end else begin
                    gap_cnt_d = gap_cnt_q - {{(GAP_WIDTH-1){1'b0}}, 1'b1};
                end
            end
            ST_DONE: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                end else begin
                    state_d = ST_ARMED;
                end
            end
            default: begin
                state_d = ST_WAIT_LOCK;
            end
        endcase
    end

    // Output and burst-datapath next values; a launch in SEND survives a same-edge stop.
    always_comb begin
        launch_d    = launch_s;
        ready_d     = (state_d == ST_ARMED);
        running_d   = (state_d == ST_SEND) || (state_d == ST_GAP);
        done_d      = (state_q == ST_DONE) && lock_s;
        blen_d      = blen_q;
        gap_len_d   = gap_len_q;
        idx_d       = idx_q;
        pkts_d      = pkts_q;
        lock_lost_d = lock_lost_q;

        if (start_burst_s) begin
            blen_d    = burst_len;
            gap_len_d = gap_cycles;
            idx_d     = 16'd0;
            pkts_d    = {COUNT_WIDTH{1'b0}};
        end else if (launch_s) begin
            idx_d = idx_q + 16'd1;
            if (pkts_q != {COUNT_WIDTH{1'b1}}) begin
                pkts_d = pkts_q + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                pkts_d = pkts_q;
            end
        end else begin
            idx_d = idx_q;
        end

        if (!lock_s && ((state_q == ST_ARMED) || (state_q == ST_SEND) ||
                        (state_q == ST_GAP) || (state_q == ST_DONE))) begin
            lock_lost_d = 1'b1;
        end else if (start_burst_s) begin
            lock_lost_d = 1'b0;
        end else begin
            lock_lost_d = lock_lost_q;
        end
    end

    // Registered outputs and latched burst parameters.
    always_ff @(posedge clk_ref156 or negedge rst_n) begin
        if (!rst_n) begin
            launch_q    <= 1'b0;
            ready_q     <= 1'b0;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            lock_lost_q <= 1'b0;
            blen_q      <= 16'd0;
            gap_len_q   <= {GAP_WIDTH{1'b0}};
            idx_q       <= 16'd0;
            pkts_q      <= {COUNT_WIDTH{1'b0}};
        end else begin
            launch_q    <= launch_d;
            ready_q     <= ready_d;
            running_q   <= running_d;
            done_q      <= done_d;
            lock_lost_q <= lock_lost_d;
            blen_q      <= blen_d;
            gap_len_q   <= gap_len_d;
            idx_q       <= idx_d;
            pkts_q      <= pkts_d;
        end
    end

    assign packet_gen_en = launch_q;
    assign ready         = ready_q;
    assign running       = running_q;
    assign done          = done_q;
    assign lock_lost     = lock_lost_q;
    assign packets_sent  = pkts_q;

endmodule

// File: tb/tb_packet_gen_sequencer.sv
// Self-checking bench for packet_gen_sequencer: expected launch times are derived
// arithmetically from burst length, gap and injected back-pressure.
module tb_packet_gen_sequencer;

    localparam int N  = 8;
    localparam int GW = 16;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pll_lock = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          gen_busy = 1'b0;
    logic [15:0]   burst_len = 16'd0;
    logic [GW-1:0] gap_cycles = '0;
    logic          packet_gen_en, ready, running, done, lock_lost;
    logic [CW-1:0] packets_sent;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    packet_gen_sequencer #(
        .LOCK_SETTLE_CYCLES(N),
        .GAP_WIDTH(GW),
        .COUNT_WIDTH(CW)
    ) dut (
        .clk_ref156(clk),
        .rst_n(rst_n),
        .pll_lock(pll_lock),
        .start(start),
        .stop(stop),
        .burst_len(burst_len),
        .gap_cycles(gap_cycles),
        .gen_busy(gen_busy),
        .packet_gen_en(packet_gen_en),
        .ready(ready),
        .running(running),
        .done(done),
        .lock_lost(lock_lost),
        .packets_sent(packets_sent)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pll_lock = 1'b0;
        tick();
        tick();
        checks++;
        if ({packet_gen_en, ready, running, done, lock_lost, packets_sent} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got en=%b rdy=%b run=%b done=%b ll=%b cnt=%0d required all 0",
                     packet_gen_en, ready, running, done, lock_lost, packets_sent);
        end
        rst_n = 1'b1;
    endtask

    // edge 1 is the first edge that samples pll_lock high; ready must rise after edge N+3
    task automatic relock();
        logic exp_r;
        pll_lock = 1'b1;
        for (int e = 1; e <= N + 3; e++) begin
            tick();
            exp_r = (e == N + 3);
            checks++;
            if (ready !== exp_r) begin
                failures++;
                $display("FAIL relock_ready edge %0d: got %b required %b", e, ready, exp_r);
            end
        end
    endtask

    task automatic test_lock_drop(input int k);
        pll_lock = 1'b1;
        repeat (k) tick();
        pll_lock = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if ({ready, lock_lost} !== 2'b00) begin
                failures++;
                $display("FAIL lock_drop k=%0d cyc %0d: got ready=%b lock_lost=%b required 0 0",
                         k, i, ready, lock_lost);
            end
        end
    endtask

    task automatic test_burst(input int len, input int gap, input int mode, input bit ign, input bit with_stop);
        int  exp_q[$];
        int  obs_q[$];
        int  dn_q[$];
        bit  busy_map[256];
        int  attempt, b, last, horizon, ign_r, got;
        foreach (busy_map[i]) busy_map[i] = 1'b0;
        attempt = 1;
        for (int k = 1; k <= len; k++) begin
            if (mode == 1) b = int'($urandom_range(0, 3));
            else if (mode == 2 && k == 2) b = 5;
            else b = 0;
            for (int j = 0; j < b; j++) busy_map[attempt + j] = 1'b1;
            exp_q.push_back(attempt + b);
            attempt = attempt + b + gap + 2;
        end
        last = exp_q[$];
        horizon = last + 4;
        ign_r = ign ? int'($urandom_range(1, last + 1)) : -1;

        checks++;
        if (ready !== 1'b1) begin
            failures++;
            $display("FAIL burst_pre_ready: got %b required 1", ready);
        end
        burst_len = 16'(len);
        gap_cycles = GW'(gap);
        start = 1'b1;
        stop = with_stop;
        tick();
        start = 1'b0;
        stop = 1'b0;
        burst_len = 16'($urandom);
        gap_cycles = GW'($urandom);
        checks++;
        if ({running, ready, lock_lost, packets_sent} !== {3'b100, 32'd0}) begin
            failures++;
            $display("FAIL burst_started len=%0d: got run=%b rdy=%b ll=%b cnt=%0d required 1 0 0 0",
                     len, running, ready, lock_lost, packets_sent);
        end
        for (int r = 1; r <= horizon; r++) begin
            gen_busy = busy_map[r];
            start = (r == ign_r);
            tick();
            if (packet_gen_en === 1'b1) obs_q.push_back(r);
            if (done === 1'b1) dn_q.push_back(r);
        end
        gen_busy = 1'b0;
        start = 1'b0;

        checks++;
        if (obs_q.size() != len) begin
            failures++;
            $display("FAIL burst_pulse_count len=%0d gap=%0d: got %0d required %0d", len, gap, obs_q.size(), len);
        end
        for (int i = 0; i < len; i++) begin
            got = (i < obs_q.size()) ? obs_q[i] : -1;
            checks++;
            if (got != exp_q[i]) begin
                failures++;
                $display("FAIL burst_pulse_time #%0d gap=%0d: got cycle %0d required %0d", i + 1, gap, got, exp_q[i]);
            end
        end
        got = (dn_q.size() == 1) ? dn_q[0] : -dn_q.size();
        checks++;
        if (got != last + 1) begin
            failures++;
            $display("FAIL burst_done: got cycle %0d required single pulse at %0d", got, last + 1);
        end
        checks++;
        if ({ready, running, packets_sent} !== {2'b10, 32'(len)}) begin
            failures++;
            $display("FAIL burst_end_state: got rdy=%b run=%b cnt=%0d required 1 0 %0d",
                     ready, running, packets_sent, len);
        end
    endtask

    task automatic test_continuous_stop(input int s);
        int exp_q[$];
        int obs_q[$];
        int ndone;
        int got;
        ndone = 0;
        for (int p = 1; p <= s; p += 2) exp_q.push_back(p);
        burst_len = 16'd0;
        gap_cycles = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int r = 1; r <= s + 10; r++) begin
            stop = (r == s);
            tick();
            if (packet_gen_en === 1'b1) obs_q.push_back(r);
            if (done === 1'b1) ndone++;
        end
        stop = 1'b0;
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL cont_pulse_count stop@%0d: got %0d required %0d", s, obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < obs_q.size()) ? obs_q[i] : -1;
            checks++;
            if (got != exp_q[i]) begin
                failures++;
                $display("FAIL cont_pulse_time #%0d: got cycle %0d required %0d", i + 1, got, exp_q[i]);
            end
        end
        checks++;
        if (ndone != 0) begin
            failures++;
            $display("FAIL cont_no_done: got %0d done pulses required 0", ndone);
        end
        checks++;
        if ({ready, running, packets_sent} !== {2'b10, 32'(exp_q.size())}) begin
            failures++;
            $display("FAIL cont_end_state: got rdy=%b run=%b cnt=%0d required 1 0 %0d",
                     ready, running, packets_sent, exp_q.size());
        end
    endtask

    task automatic test_lock_loss(input int gap, input int d);
        int exp_q[$];
        int obs_q[$];
        int ndone;
        int got;
        ndone = 0;
        for (int p = 1; p <= d + 1; p += gap + 2) exp_q.push_back(p);
        burst_len = 16'd0;
        gap_cycles = GW'(gap);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int r = 1; r <= d + 20; r++) begin
            pll_lock = (r < d);
            tick();
            if (packet_gen_en === 1'b1) obs_q.push_back(r);
            if (done === 1'b1) ndone++;
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL lockloss_pulse_count d=%0d: got %0d required %0d", d, obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < obs_q.size()) ? obs_q[i] : -1;
            checks++;
            if (got != exp_q[i]) begin
                failures++;
                $display("FAIL lockloss_pulse_time #%0d: got cycle %0d required %0d", i + 1, got, exp_q[i]);
            end
        end
        checks++;
        if ({lock_lost, ready, running, done} !== 4'b1000 || ndone != 0) begin
            failures++;
            $display("FAIL lockloss_state: got ll=%b rdy=%b run=%b done=%b ndone=%0d required 1 0 0 0 0",
                     lock_lost, ready, running, done, ndone);
        end
        relock();
        checks++;
        if (lock_lost !== 1'b1) begin
            failures++;
            $display("FAIL lockloss_sticky: got %b required 1", lock_lost);
        end
        test_burst(2, int'($urandom_range(0, 4)), 0, 1'b0, 1'b0);
    endtask

    task automatic test_async_reset();
        burst_len = 16'd0;
        gap_cycles = GW'(1);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat ($urandom_range(2, 9)) tick();
        checks++;
        if (running !== 1'b1) begin
            failures++;
            $display("FAIL areset_pre_running: got %b required 1", running);
        end
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({packet_gen_en, ready, running, done, lock_lost, packets_sent} !== '0) begin
            failures++;
            $display("FAIL areset_outputs: got en=%b rdy=%b run=%b done=%b ll=%b cnt=%0d required all 0",
                     packet_gen_en, ready, running, done, lock_lost, packets_sent);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        relock();
    endtask

    initial begin
        test_reset();
        test_lock_drop(6);
        test_lock_drop(int'($urandom_range(1, N)));
        relock();
        test_burst(3, 4, 0, 1'b0, 1'b0);
        test_burst(3, 4, 2, 1'b0, 1'b0);
        test_continuous_stop(20);
        test_continuous_stop(21);
        for (int i = 0; i < 6; i++) begin
            test_burst(int'($urandom_range(1, 6)), int'($urandom_range(0, 6)), 1, 1'b1, 1'b0);
        end
        test_burst(3, 4, 0, 1'b1, 1'b1);
        test_continuous_stop(int'($urandom_range(2, 30)));
        test_lock_loss(int'($urandom_range(0, 3)), int'($urandom_range(3, 20)));
        test_async_reset();
        test_burst(int'($urandom_range(1, 4)), int'($urandom_range(0, 3)), 1, 1'b0, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
